// File: rtl/crc_frame_engine.sv
// Keyed CRC frame engine: generate mode buffers a frame and appends its CRC; check mode tests the residue.
// Latency: first output word 1 cycle after the last input accept; chk_done 1 cycle after the last accept.
// Backpressure: in_ready drops only at the buffer limit; output word/flags hold while out_ready is low.
module crc_frame_engine #(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY   = 8'h07,
  parameter int               KEY_W  = 16,
  parameter int               DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [KEY_W-1:0]  key,
  input  logic              mode_chk,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_is_crc,
  input  logic              out_ready,
  output logic              chk_done,
  output logic              chk_ok,
  output logic              ovf_err,
  output logic              busy
);

  localparam int NCHUNK = CRC_W / DATA_W;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + NCHUNK + 1);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // Check frames carry the trailing CRC words on top of the payload limit.
  localparam logic [CW-1:0] GEN_LIM = CW'(DEPTH);
  localparam logic [CW-1:0] CHK_LIM = CW'(DEPTH + NCHUNK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_SEND_DATA,
    S_SEND_CRC,
    S_CHECK
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [KW-1:0]      chunk_q, chunk_d;
  logic               chk_ok_q, chk_ok_d;
  logic               ovf_q, ovf_d;

  logic [DATA_W-1:0]  buf_q [DEPTH];
  logic               buf_we;
  logic [AW-1:0]      buf_wa;

  logic [CRC_W-1:0]   seed;
  logic [CRC_W-1:0]   crc_base;
  logic [CRC_W-1:0]   crc_next;
  logic [CRC_W-1:0]   crc_sh;
  logic [CW-1:0]      lim;
  logic               last_chunk;

  // MSB-first, non-reflected fold of one word into the running CRC.
  function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] c_in,
                                                  input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  assign seed       = key[CRC_W-1:0] ^ key[KEY_W-1 -: CRC_W];
  // The first word of a frame starts from the key-derived seed, later words from the running CRC.
  assign crc_base   = (state_q == S_IDLE) ? seed : crc_q;
  assign crc_next   = crc_update(crc_base, in_data);
  // Shift the chunk being sent up to the top so the MS chunk goes first.
  assign crc_sh     = crc_q << (int'(chunk_q) * DATA_W);
  assign last_chunk = (chunk_q == KW'(NCHUNK - 1));
  assign lim        = mode_q ? CHK_LIM : GEN_LIM;
  assign chk_ok     = chk_ok_q;
  assign ovf_err    = ovf_q;
  assign busy       = (state_q != S_IDLE);

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    chunk_d    = chunk_q;
    chk_ok_d   = chk_ok_q;
    ovf_d      = 1'b0;
    buf_we     = 1'b0;
    buf_wa     = wr_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_is_crc = 1'b0;
    out_data   = '0;
    chk_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mode_d  = mode_chk;
          crc_d   = crc_next;
          cnt_d   = CW'(1);
          wr_d    = AW'(1);
          rd_d    = '0;
          chunk_d = '0;
          if (!mode_chk) begin
            buf_we = 1'b1;
            buf_wa = '0;
          end
          if (in_last) begin
            if (mode_chk) begin
              chk_ok_d = (crc_next == '0);
              state_d  = S_CHECK;
            end else begin
              state_d  = S_SEND_DATA;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        in_ready = (cnt_q < lim);
        if (in_valid && in_ready) begin
          crc_d = crc_next;
          cnt_d = cnt_q + CW'(1);
          if (!mode_q) begin
            buf_we = 1'b1;
            wr_d   = wr_q + AW'(1);
          end
          if (in_last) begin
            if (mode_q) begin
              chk_ok_d = (crc_next == '0);
              state_d  = S_CHECK;
            end else begin
              state_d  = S_SEND_DATA;
            end
          end else if ((cnt_q + CW'(1)) == lim) begin
            // Frame too long: flush everything and swallow the rest of it.
            ovf_d   = 1'b1;
            cnt_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = S_IDLE;
      end

      S_SEND_DATA: begin
        out_valid = 1'b1;
        out_data  = buf_q[rd_q];
        if (out_ready) begin
          rd_d  = rd_q + AW'(1);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            chunk_d = '0;
            state_d = S_SEND_CRC;
          end
        end
      end

      S_SEND_CRC: begin
        out_valid  = 1'b1;
        out_is_crc = 1'b1;
        out_data   = crc_sh[CRC_W-1 -: DATA_W];
        out_last   = last_chunk;
        if (out_ready) begin
          if (last_chunk) state_d = S_IDLE;
          else            chunk_d = chunk_q + KW'(1);
        end
      end

      S_CHECK: begin
        chk_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and CRC state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      crc_q    <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      chunk_q  <= '0;
      chk_ok_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      chunk_q  <= chunk_d;
      chk_ok_q <= chk_ok_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload buffer; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (buf_we && !reset) buf_q[buf_wa] <= in_data;
  end

endmodule

// File: tb/tb_crc_frame_engine.sv
// Bench for crc_frame_engine: directed frames plus random frames against a long-division CRC model.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// out_ready pattern selectable per frame: always, toggling, random, or held low.
module tb_crc_frame_engine;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic [15:0] key;
  logic        mode_chk;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_is_crc;
  logic        out_ready;
  logic        chk_done;
  logic        chk_ok;
  logic        ovf_err;
  logic        busy;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          cyc      = 0;
  int          rdy_mode = 0;
  int          ovf_cnt  = 0;
  int          chk_cnt  = 0;
  int          ovf_cyc  = 0;
  logic        chk_ok_seen = 1'b0;
  logic [9:0]  got_q [$];
  int          acc_q [$];
  logic        stall_q = 1'b0;
  logic [7:0]  stall_dat = 8'h00;

  crc_frame_engine #(
    .DATA_W(8), .CRC_W(8), .POLY(8'h07), .KEY_W(16), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .mode_chk(mode_chk),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_is_crc(out_is_crc),
    .out_ready(out_ready), .chk_done(chk_done), .chk_ok(chk_ok), .ovf_err(ovf_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC: polynomial long division of the seed-adjusted, zero-augmented bit string.
  function automatic logic [7:0] model_crc(input logic [15:0] k, input logic [7:0] w[$]);
    bit         bits [$];
    logic [7:0] seed;
    logic [8:0] gpoly;
    logic [7:0] rem;
    int         n;
    gpoly = 9'h107;
    seed  = k[7:0] ^ k[15:8];
    foreach (w[i]) for (int b = 7; b >= 0; b--) bits.push_back(w[i][b]);
    for (int b = 0; b < 8; b++) bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) bits[b] = bits[b] ^ seed[7-b];
    n = bits.size();
    for (int i = 0; i < n - 8; i++)
      if (bits[i]) for (int j = 0; j < 9; j++) bits[i+j] = bits[i+j] ^ gpoly[8-j];
    for (int b = 0; b < 8; b++) rem[7-b] = bits[n-8+b];
    return rem;
  endfunction

  // out_ready pattern generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: collects handshakes and pulses, checks stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_vld", 32'(out_valid), 32'(1));
        check("hold_dat", 32'(out_data), 32'(stall_dat));
      end
      if (out_valid && out_ready) got_q.push_back({out_is_crc, out_last, out_data});
      if (chk_done) begin
        chk_cnt++;
        chk_ok_seen = chk_ok;
      end
      if (ovf_err) begin
        ovf_cnt++;
        ovf_cyc = cyc;
      end
      stall_q   = out_valid && !out_ready;
      stall_dat = out_data;
    end
  end

  task automatic drive_word(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic chk, input logic [15:0] k,
                           input logic [7:0] w[$], input int rmode, output logic [7:0] crc_seen);
    int         n;
    int         lim;
    bit         ovf_exp;
    logic [7:0] exp_crc;
    logic [9:0] exp_w;
    logic [9:0] g;
    int         t;
    n        = w.size();
    lim      = chk ? DEPTH + 1 : DEPTH;
    ovf_exp  = (n > lim);
    exp_crc  = model_crc(k, w);
    crc_seen = 8'h00;
    got_q.delete();
    acc_q.delete();
    ovf_cnt  = 0;
    chk_cnt  = 0;
    rdy_mode = rmode;
    mode_chk = chk;
    key      = k;
    for (int i = 0; i < n; i++) drive_word(w[i], (i == n - 1));
    if (!chk && !ovf_exp) check({name, "_lat"}, 32'(out_valid), 32'(1));
    t = 0;
    while (busy && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) check({name, "_timeout"}, 32'(busy), 32'(0));
    check({name, "_ovf"}, 32'(ovf_cnt), ovf_exp ? 32'(1) : 32'(0));
    if (ovf_exp || chk) begin
      check({name, "_nout"}, 32'(got_q.size()), 32'(0));
    end else begin
      check({name, "_nout"}, 32'(got_q.size()), 32'(n + 1));
      for (int i = 0; i <= n && i < got_q.size(); i++) begin
        exp_w = (i < n) ? {2'b00, w[i]} : {2'b11, exp_crc};
        check({name, "_word"}, 32'(got_q[i]), 32'(exp_w));
      end
      if (got_q.size() == n + 1) begin
        g        = got_q[n];
        crc_seen = g[7:0];
      end
    end
    if (chk) begin
      check({name, "_chkdone"}, 32'(chk_cnt), ovf_exp ? 32'(0) : 32'(1));
      if (!ovf_exp) begin
        check({name, "_chkok"}, 32'(chk_ok_seen), 32'(exp_crc == 8'h00));
        check({name, "_okhold"}, 32'(chk_ok), 32'(exp_crc == 8'h00));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w [$];
    logic [7:0] p [$];
    logic [7:0] cs;
    logic [7:0] c8;
    logic [15:0] k;
    bit          c;
    int          len;

    reset = 1'b1; key = 16'h0; mode_chk = 1'b0;
    in_data = 8'h0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_out_is_crc", 32'(out_is_crc), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_chk_done", 32'(chk_done), 32'(0));
    check("rst_chk_ok", 32'(chk_ok), 32'(0));
    check("rst_ovf_err", 32'(ovf_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Standard check string, zero key.
    w = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame("gen9", 1'b0, 16'h0000, w, 0, cs);
    check("gen9_crc", 32'(cs), 32'(8'hF4));

    // Seed from the upper key byte, single-word frame.
    w = {8'h00};
    run_frame("gen1", 1'b0, 16'h0100, w, 0, cs);
    check("gen1_crc", 32'(cs), 32'(8'h07));

    w = {8'h01, 8'h07};
    run_frame("chk_pass", 1'b1, 16'h0000, w, 0, cs);
    check("chk_pass_ok", 32'(chk_ok), 32'(1));
    w = {8'h01, 8'h06};
    run_frame("chk_fail", 1'b1, 16'h0000, w, 0, cs);
    check("chk_fail_ok", 32'(chk_ok), 32'(0));

    // Seventeen-word generate frame overflows after word sixteen.
    w.delete();
    for (int i = 0; i < 17; i++) w.push_back(8'(8'h40 + i));
    run_frame("ovf", 1'b0, 16'h1234, w, 0, cs);
    check("ovf_pulse_cyc", 32'(ovf_cyc), 32'(acc_q[15]));
    check("ovf_busy_after", 32'(busy), 32'(0));
    w = {8'hA5, 8'h5A};
    run_frame("post_ovf", 1'b0, 16'h0000, w, 0, cs);

    // Toggling out_ready.
    w = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame("bp", 1'b0, 16'h0000, w, 1, cs);
    check("bp_crc", 32'(cs), 32'(8'hF4));

    // Leave chk_ok high, then reset in the middle of sending.
    w = {8'h01, 8'h07};
    run_frame("chk_pre_rst", 1'b1, 16'h0000, w, 0, cs);
    rdy_mode = 3;
    mode_chk = 1'b0;
    key      = 16'h0000;
    w = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) drive_word(w[i], (i == 8));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_pre_vld", 32'(out_valid), 32'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_vld", 32'(out_valid), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_ok", 32'(chk_ok), 32'(0));
    check("rst_mid_dat", 32'(out_data), 32'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    w = {8'h00};
    run_frame("rst_fresh", 1'b0, 16'h0100, w, 0, cs);
    check("rst_fresh_crc", 32'(cs), 32'(8'h07));

    // Random frames in both modes, some too long, some with a correct trailing CRC.
    for (int r = 0; r < 40; r++) begin
      p.delete();
      c   = ($urandom_range(0, 2) == 0);
      k   = 16'($urandom);
      len = $urandom_range(1, 19);
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      if (c && $urandom_range(0, 1) == 1) begin
        c8 = model_crc(k, p);
        p.push_back(c8);
      end
      run_frame($sformatf("rnd%0d", r), c, k, p, $urandom_range(0, 2), cs);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
